stream_unpacker: RTL and testbench

Read-side width converter for the sample path. It accepts wide words over a valid/ready stream, typically straight from a sync FIFO's read port, and emits them as a sequence of narrow chunks on a valid/ready stream toward the DSP/modulator. It sustains one chunk per cycle with no bubbles between words, and carries a packet-end flag through to the final chunk.

---
 rtl/sdr_stream_pkg.sv | 14 +
 rtl/stream_unpacker_if.sv | 26 ++
 rtl/stream_unpacker.sv | 91 +++++++++
 tb/tb_stream_unpacker.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sdr_stream_pkg.sv
// Shared types and elaboration helpers for the sample-path stream blocks.
package sdr_stream_pkg;

    typedef enum logic {
        EMPTY  = 1'b0,
        ACTIVE = 1'b1
    } unpack_state_t;

    // A wide word must split into a whole number of non-empty chunks.
    function automatic bit widthsOk(input int inWidth, input int outWidth);
        return (outWidth >= 1) && (inWidth >= outWidth) && ((inWidth % outWidth) == 0);
    endfunction

endpackage

// File: rtl/stream_unpacker_if.sv
// Wide-in / narrow-out valid-ready bundle; the unpacker sits on the slave side.
interface stream_unpacker_if #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8
);

    logic                 in_valid;
    logic                 in_ready;
    logic [IN_WIDTH-1:0]  in_data;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_last;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

endinterface

// File: rtl/stream_unpacker.sv
// Splits each wide input word into RATIO narrow chunks, one per cycle,
// refilling on the last chunk so consecutive words stream without bubbles.
module stream_unpacker
    import sdr_stream_pkg::*;
#(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input logic              clk,
    input logic              rst,
    stream_unpacker_if.slave bus
);

    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    if (!widthsOk(IN_WIDTH, OUT_WIDTH)) begin : g_badWidths
        $error("stream_unpacker: IN_WIDTH must be a nonzero multiple of OUT_WIDTH");
    end

    unpack_state_t        state_q, state_d;
    logic [IN_WIDTH-1:0]  holdData_q, holdData_d;
    logic                 holdLast_q, holdLast_d;
    logic [IDX_W-1:0]     idx_q, idx_d;

    logic inReady;
    logic inXfer;
    logic outXfer;
    logic lastChunk;
    int   chunkSel;

    assign lastChunk = (idx_q == LAST_IDX);
    assign outXfer   = (state_q == ACTIVE) & bus.out_ready;
    // Ready depends on out_ready so a fresh word slides in behind the last chunk.
    assign inReady   = ~rst & ((state_q == EMPTY) | (outXfer & lastChunk));
    assign inXfer    = bus.in_valid & inReady;

    assign chunkSel      = MSB_FIRST ? (RATIO - 1 - int'(idx_q)) : int'(idx_q);
    assign bus.in_ready  = inReady;
    assign bus.out_valid = (state_q == ACTIVE);
    assign bus.out_data  = holdData_q[chunkSel*OUT_WIDTH +: OUT_WIDTH];
    assign bus.out_last  = holdLast_q & lastChunk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            holdData_q <= '0;
            holdLast_q <= 1'b0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            holdData_q <= holdData_d;
            holdLast_q <= holdLast_d;
            idx_q      <= idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        holdData_d = holdData_q;
        holdLast_d = holdLast_q;
        idx_d      = idx_q;
        case (state_q)
            EMPTY: begin
                if (inXfer) begin
                    holdData_d = bus.in_data;
                    holdLast_d = bus.in_last;
                    idx_d      = '0;
                    state_d    = ACTIVE;
                end
            end
            ACTIVE: begin
                if (outXfer) begin
                    if (!lastChunk) begin
                        idx_d = idx_q + IDX_W'(1);
                    end else if (inXfer) begin
                        holdData_d = bus.in_data;
                        holdLast_d = bus.in_last;
                        idx_d      = '0;
                    end else begin
                        idx_d   = '0;
                        state_d = EMPTY;
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_stream_unpacker.sv
// Directed bench for stream_unpacker: LSB-first, MSB-first and 8->8 instances.
module tb_stream_unpacker;

    logic clk = 1'b0;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    stream_unpacker_if #(.IN_WIDTH(32), .OUT_WIDTH(8)) lsbIf ();
    stream_unpacker_if #(.IN_WIDTH(32), .OUT_WIDTH(8)) msbIf ();
    stream_unpacker_if #(.IN_WIDTH(8),  .OUT_WIDTH(8)) r1If ();

    stream_unpacker #(.IN_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b0)) dutLsb (
        .clk(clk), .rst(rst), .bus(lsbIf)
    );
    stream_unpacker #(.IN_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b1)) dutMsb (
        .clk(clk), .rst(rst), .bus(msbIf)
    );
    stream_unpacker #(.IN_WIDTH(8), .OUT_WIDTH(8), .MSB_FIRST(1'b0)) dutR1 (
        .clk(clk), .rst(rst), .bus(r1If)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Both 32->8 instances always see the same upstream/downstream stimulus.
    task automatic applyStimulus(input logic valid, input logic [31:0] data,
                                 input logic last, input logic outReady);
        lsbIf.in_valid  = valid;
        lsbIf.in_data   = data;
        lsbIf.in_last   = last;
        lsbIf.out_ready = outReady;
        msbIf.in_valid  = valid;
        msbIf.in_data   = data;
        msbIf.in_last   = last;
        msbIf.out_ready = outReady;
    endtask

    logic [31:0] wordQ[$];
    logic        lastQ[$];
    logic [7:0]  r1Data[100];
    logic        r1Last[100];
    logic [7:0]  expByte;
    logic [7:0]  heldData;
    logic        heldLast;
    logic        holdPending;
    int          sent;
    int          done;
    int          chunkIdx;
    int          cycles;

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        r1If.in_valid  = 1'b0;
        r1If.in_data   = 8'h0;
        r1If.in_last   = 1'b0;
        r1If.out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_lsb_out_valid", lsbIf.out_valid, 0);
        checkOutput("rst_lsb_out_data",  lsbIf.out_data,  0);
        checkOutput("rst_lsb_out_last",  lsbIf.out_last,  0);
        checkOutput("rst_lsb_in_ready",  lsbIf.in_ready,  0);
        checkOutput("rst_r1_in_ready",   r1If.in_ready,   0);
        rst = 1'b0;
        #1;
        checkOutput("rel_lsb_in_ready", lsbIf.in_ready, 1);
        checkOutput("rel_r1_in_ready",  r1If.in_ready,  1);

        // Basic: 0x44332211 with in_last, LSB and MSB first
        @(negedge clk);
        applyStimulus(1'b1, 32'h44332211, 1'b1, 1'b1);
        #1;
        checkOutput("basic_in_ready", lsbIf.in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
            #1;
            checkOutput($sformatf("basic_lsb_valid%0d", i), lsbIf.out_valid, 1);
            checkOutput($sformatf("basic_lsb_data%0d", i), lsbIf.out_data, 8'(8'h11 * (i + 1)));
            checkOutput($sformatf("basic_lsb_last%0d", i), lsbIf.out_last, (i == 3));
            checkOutput($sformatf("basic_lsb_ready%0d", i), lsbIf.in_ready, (i == 3));
            checkOutput($sformatf("basic_msb_data%0d", i), msbIf.out_data, 8'(8'h11 * (4 - i)));
            checkOutput($sformatf("basic_msb_last%0d", i), msbIf.out_last, (i == 3));
        end
        @(negedge clk);
        #1;
        checkOutput("basic_drain_valid", lsbIf.out_valid, 0);
        checkOutput("basic_drain_ready", lsbIf.in_ready, 1);

        // Back-to-back words with in_valid held high
        @(negedge clk);
        applyStimulus(1'b1, 32'hA3A2A1A0, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) applyStimulus(1'b1, 32'hB3B2B1B0, 1'b1, 1'b1);
            if (k == 4) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
            #1;
            expByte = 8'((k < 4 ? 8'hA0 : 8'hB0) + (k % 4));
            checkOutput($sformatf("b2b_valid%0d", k), lsbIf.out_valid, 1);
            checkOutput($sformatf("b2b_data%0d", k), lsbIf.out_data, expByte);
            checkOutput($sformatf("b2b_ready%0d", k), lsbIf.in_ready, ((k % 4) == 3));
            checkOutput($sformatf("b2b_last%0d", k), lsbIf.out_last, (k == 7));
            expByte = 8'((k < 4 ? 8'hA3 : 8'hB3) - (k % 4));
            checkOutput($sformatf("b2b_msb_data%0d", k), msbIf.out_data, expByte);
        end
        @(negedge clk);
        #1;
        checkOutput("b2b_drain_valid", lsbIf.out_valid, 0);

        // Directed backpressure: chunk must hold while out_ready is low
        @(negedge clk);
        applyStimulus(1'b1, 32'h44332211, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
            #1;
            checkOutput($sformatf("hold_valid%0d", i), lsbIf.out_valid, 1);
            checkOutput($sformatf("hold_data%0d", i), lsbIf.out_data, 8'h11);
            checkOutput($sformatf("hold_ready%0d", i), lsbIf.in_ready, 0);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
            #1;
            checkOutput($sformatf("release_data%0d", i), lsbIf.out_data, 8'(8'h11 * (i + 1)));
        end

        // Reset mid-word discards the remaining chunks
        @(negedge clk);
        applyStimulus(1'b1, 32'hDDCCBBAA, 1'b1, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        #1;
        checkOutput("abort_first_chunk", lsbIf.out_data, 8'hAA);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("abort_out_valid", lsbIf.out_valid, 0);
        checkOutput("abort_out_data",  lsbIf.out_data,  0);
        checkOutput("abort_out_last",  lsbIf.out_last,  0);
        checkOutput("abort_in_ready",  lsbIf.in_ready,  0);
        checkOutput("abort_msb_valid", msbIf.out_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("abort_rel_ready", lsbIf.in_ready,  1);
        checkOutput("abort_rel_valid", lsbIf.out_valid, 0);

        // Random backpressure against a word scoreboard
        sent        = 0;
        done        = 0;
        chunkIdx    = 0;
        cycles      = 0;
        holdPending = 1'b0;
        heldData    = 8'h0;
        heldLast    = 1'b0;
        while ((sent < 1000 || wordQ.size() != 0) && cycles < 20000) begin
            @(negedge clk);
            lsbIf.in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            lsbIf.in_data   = $urandom;
            lsbIf.in_last   = 1'($urandom_range(0, 1));
            lsbIf.out_ready = 1'($urandom_range(0, 1));
            #1;
            if (holdPending) begin
                checkOutput("bp_hold_valid", lsbIf.out_valid, 1);
                checkOutput("bp_hold_data",  lsbIf.out_data,  heldData);
                checkOutput("bp_hold_last",  lsbIf.out_last,  heldLast);
            end
            if (lsbIf.in_valid && lsbIf.in_ready) begin
                wordQ.push_back(lsbIf.in_data);
                lastQ.push_back(lsbIf.in_last);
                sent++;
            end
            if (lsbIf.out_valid && lsbIf.out_ready) begin
                if (wordQ.size() == 0) begin
                    checkOutput("bp_spurious_chunk", lsbIf.out_valid, 0);
                end else begin
                    expByte = 8'(wordQ[0] >> (8 * chunkIdx));
                    checkOutput("bp_data", lsbIf.out_data, expByte);
                    checkOutput("bp_last", lsbIf.out_last, lastQ[0] && (chunkIdx == 3));
                    chunkIdx++;
                    if (chunkIdx == 4) begin
                        void'(wordQ.pop_front());
                        void'(lastQ.pop_front());
                        chunkIdx = 0;
                        done++;
                    end
                end
            end
            holdPending = lsbIf.out_valid && !lsbIf.out_ready;
            heldData    = lsbIf.out_data;
            heldLast    = lsbIf.out_last;
            cycles++;
        end
        checkOutput("bp_words_done", done, 1000);
        @(negedge clk);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);

        // RATIO=1: full-rate pass-through with one cycle of latency
        for (int k = 0; k <= 100; k++) begin
            @(negedge clk);
            if (k < 100) begin
                r1Data[k]     = 8'($urandom);
                r1Last[k]     = 1'($urandom_range(0, 1));
                r1If.in_valid = 1'b1;
                r1If.in_data  = r1Data[k];
                r1If.in_last  = r1Last[k];
            end else begin
                r1If.in_valid = 1'b0;
            end
            r1If.out_ready = 1'b1;
            #1;
            if (k > 0) begin
                checkOutput($sformatf("r1_valid%0d", k), r1If.out_valid, 1);
                checkOutput($sformatf("r1_data%0d", k), r1If.out_data, r1Data[k-1]);
                checkOutput($sformatf("r1_last%0d", k), r1If.out_last, r1Last[k-1]);
            end
            if (k < 100) begin
                checkOutput($sformatf("r1_ready%0d", k), r1If.in_ready, 1);
            end
        end
        @(negedge clk);
        #1;
        checkOutput("r1_drain_valid", r1If.out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
